// File: rtl/operand_pkg.sv
// Shared constants for the operand fetch stage, register file wrapper
// and decode hazard logic: default widths and the hardwired zero register.
package operand_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_resolve.sv
// Priority mux resolving one operand against EX/WB results and the zero
// register. Ports: source/use, EX and WB forward buses, RF data in, oOp out.
module operand_resolve
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  iUse,
  input  logic [ADDR_WIDTH-1:0] iSrc,
  input  logic                  iExEn,
  input  logic [ADDR_WIDTH-1:0] iExAddr,
  input  logic [DATA_WIDTH-1:0] iExData,
  input  logic                  iWbEn,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData,
  input  logic [DATA_WIDTH-1:0] iRfData,
  output logic [DATA_WIDTH-1:0] oOp
);

  logic is_zero;

  assign is_zero = !iUse || (iSrc == ADDR_WIDTH'(REG_ZERO));

  // Priority chain: zero rule, then EX (youngest), then WB, then RF.
  always_comb begin
    oOp = iRfData;
    if (is_zero) begin
      oOp = '0;
    end else if (iExEn && (iExAddr == iSrc)) begin
      oOp = iExData;
    end else if (iWbEn && (iWbAddr == iSrc)) begin
      oOp = iWbData;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: S1 issues RF reads, S2 holds resolved operands.
// Ports: decode in (valid/ready), RF read ports, EX/WB forwards, execute out.
module operand_fetch
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [ADDR_WIDTH-1:0] iSrc0,
  input  logic [ADDR_WIDTH-1:0] iSrc1,
  input  logic                  iUse0,
  input  logic                  iUse1,
  input  logic [ADDR_WIDTH-1:0] iDest,
  output logic [ADDR_WIDTH-1:0] oAddrRead0,
  output logic [ADDR_WIDTH-1:0] oAddrRead1,
  output logic                  oEnRead0,
  output logic                  oEnRead1,
  input  logic [DATA_WIDTH-1:0] iDataRead0,
  input  logic [DATA_WIDTH-1:0] iDataRead1,
  input  logic                  iExEn,
  input  logic [ADDR_WIDTH-1:0] iExAddr,
  input  logic [DATA_WIDTH-1:0] iExData,
  input  logic                  iExIsLoad,
  input  logic                  iWbEn,
  input  logic [ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0] iWbData,
  input  logic                  iFlush,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oOpA,
  output logic [DATA_WIDTH-1:0] oOpB,
  output logic [ADDR_WIDTH-1:0] oDest
);

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_src0_q, s1_src0_d;
  logic [ADDR_WIDTH-1:0] s1_src1_q, s1_src1_d;
  logic                  s1_use0_q, s1_use0_d;
  logic                  s1_use1_q, s1_use1_d;
  logic [ADDR_WIDTH-1:0] s1_dest_q, s1_dest_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_src0_q, s2_src0_d;
  logic [ADDR_WIDTH-1:0] s2_src1_q, s2_src1_d;
  logic                  s2_use0_q, s2_use0_d;
  logic                  s2_use1_q, s2_use1_d;
  logic [ADDR_WIDTH-1:0] s2_dest_q, s2_dest_d;
  logic [DATA_WIDTH-1:0] s2_op_a_q, s2_op_a_d;
  logic [DATA_WIDTH-1:0] s2_op_b_q, s2_op_b_d;

  logic                  hit0, hit1, hazard;
  logic                  stall, s1_hold, s1_adv, accept;
  logic [DATA_WIDTH-1:0] res_a, res_b, snp_a, snp_b;

  // Load in EX targets a used, nonzero S1 source: data not ready yet.
  assign hit0 = s1_use0_q
             && (s1_src0_q != ADDR_WIDTH'(REG_ZERO))
             && (iExAddr == s1_src0_q);
  assign hit1 = s1_use1_q
             && (s1_src1_q != ADDR_WIDTH'(REG_ZERO))
             && (iExAddr == s1_src1_q);
  assign hazard = s1_valid_q && iExEn && iExIsLoad && (hit0 || hit1);

  assign stall   = s2_valid_q && !iReady;
  assign s1_hold = s1_valid_q && (hazard || stall);
  assign s1_adv  = s1_valid_q && !hazard;
  assign oReady  = !s1_hold;
  assign accept  = iValid && oReady;

  // A held S1 re-reads every cycle so its RF data stays one cycle fresh.
  always_comb begin
    oAddrRead0 = '0;
    oAddrRead1 = '0;
    oEnRead0   = 1'b0;
    oEnRead1   = 1'b0;
    if (s1_hold) begin
      oAddrRead0 = s1_src0_q;
      oAddrRead1 = s1_src1_q;
      oEnRead0   = s1_use0_q;
      oEnRead1   = s1_use1_q;
    end else if (accept) begin
      oAddrRead0 = iSrc0;
      oAddrRead1 = iSrc1;
      oEnRead0   = iUse0;
      oEnRead1   = iUse1;
    end
  end

  operand_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_res_a (
    .iUse    (s1_use0_q),
    .iSrc    (s1_src0_q),
    .iExEn   (iExEn),
    .iExAddr (iExAddr),
    .iExData (iExData),
    .iWbEn   (iWbEn),
    .iWbAddr (iWbAddr),
    .iWbData (iWbData),
    .iRfData (iDataRead0),
    .oOp     (res_a)
  );

  operand_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_res_b (
    .iUse    (s1_use1_q),
    .iSrc    (s1_src1_q),
    .iExEn   (iExEn),
    .iExAddr (iExAddr),
    .iExData (iExData),
    .iWbEn   (iWbEn),
    .iWbAddr (iWbAddr),
    .iWbData (iWbData),
    .iRfData (iDataRead1),
    .oOp     (res_b)
  );

  // Snoop path for a stalled S2: WB only, held operand as fallback.
  operand_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_snp_a (
    .iUse    (s2_use0_q),
    .iSrc    (s2_src0_q),
    .iExEn   (1'b0),
    .iExAddr (iExAddr),
    .iExData (iExData),
    .iWbEn   (iWbEn),
    .iWbAddr (iWbAddr),
    .iWbData (iWbData),
    .iRfData (s2_op_a_q),
    .oOp     (snp_a)
  );

  operand_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_snp_b (
    .iUse    (s2_use1_q),
    .iSrc    (s2_src1_q),
    .iExEn   (1'b0),
    .iExAddr (iExAddr),
    .iExData (iExData),
    .iWbEn   (iWbEn),
    .iWbAddr (iWbAddr),
    .iWbData (iWbData),
    .iRfData (s2_op_b_q),
    .oOp     (snp_b)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src0_d  = s1_src0_q;
    s1_src1_d  = s1_src1_q;
    s1_use0_d  = s1_use0_q;
    s1_use1_d  = s1_use1_q;
    s1_dest_d  = s1_dest_q;
    s2_valid_d = s2_valid_q;
    s2_src0_d  = s2_src0_q;
    s2_src1_d  = s2_src1_q;
    s2_use0_d  = s2_use0_q;
    s2_use1_d  = s2_use1_q;
    s2_dest_d  = s2_dest_q;
    s2_op_a_d  = s2_op_a_q;
    s2_op_b_d  = s2_op_b_q;
    if (iFlush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (stall) begin
        s2_op_a_d = snp_a;
        s2_op_b_d = snp_b;
      end else begin
        // Hazard or empty S1 leaves a bubble in S2.
        s2_valid_d = s1_adv;
        if (s1_adv) begin
          s2_src0_d = s1_src0_q;
          s2_src1_d = s1_src1_q;
          s2_use0_d = s1_use0_q;
          s2_use1_d = s1_use1_q;
          s2_dest_d = s1_dest_q;
          s2_op_a_d = res_a;
          s2_op_b_d = res_b;
        end
      end
      if (!s1_hold) begin
        s1_valid_d = accept;
        if (accept) begin
          s1_src0_d = iSrc0;
          s1_src1_d = iSrc1;
          s1_use0_d = iUse0;
          s1_use1_d = iUse1;
          s1_dest_d = iDest;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid_q <= 1'b0;
      s1_src0_q  <= '0;
      s1_src1_q  <= '0;
      s1_use0_q  <= 1'b0;
      s1_use1_q  <= 1'b0;
      s1_dest_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_src0_q  <= '0;
      s2_src1_q  <= '0;
      s2_use0_q  <= 1'b0;
      s2_use1_q  <= 1'b0;
      s2_dest_q  <= '0;
      s2_op_a_q  <= '0;
      s2_op_b_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src0_q  <= s1_src0_d;
      s1_src1_q  <= s1_src1_d;
      s1_use0_q  <= s1_use0_d;
      s1_use1_q  <= s1_use1_d;
      s1_dest_q  <= s1_dest_d;
      s2_valid_q <= s2_valid_d;
      s2_src0_q  <= s2_src0_d;
      s2_src1_q  <= s2_src1_d;
      s2_use0_q  <= s2_use0_d;
      s2_use1_q  <= s2_use1_d;
      s2_dest_q  <= s2_dest_d;
      s2_op_a_q  <= s2_op_a_d;
      s2_op_b_q  <= s2_op_b_d;
    end
  end

  assign oValid = s2_valid_q;
  assign oOpA   = s2_op_a_q;
  assign oOpB   = s2_op_b_q;
  assign oDest  = s2_dest_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table through a scoreboard plus
// directed load-use, backpressure, flush and reset sequences.
module tb_operand_fetch;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [4:0]  iSrc0, iSrc1, iDest;
  logic        iUse0, iUse1;
  logic [4:0]  oAddrRead0, oAddrRead1;
  logic        oEnRead0, oEnRead1;
  logic [31:0] iDataRead0, iDataRead1;
  logic        iExEn, iExIsLoad, iWbEn;
  logic [4:0]  iExAddr, iWbAddr;
  logic [31:0] iExData, iWbData;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [31:0] oOpA, oOpB;
  logic [4:0]  oDest;

  operand_fetch dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iSrc0      (iSrc0),
    .iSrc1      (iSrc1),
    .iUse0      (iUse0),
    .iUse1      (iUse1),
    .iDest      (iDest),
    .oAddrRead0 (oAddrRead0),
    .oAddrRead1 (oAddrRead1),
    .oEnRead0   (oEnRead0),
    .oEnRead1   (oEnRead1),
    .iDataRead0 (iDataRead0),
    .iDataRead1 (iDataRead1),
    .iExEn      (iExEn),
    .iExAddr    (iExAddr),
    .iExData    (iExData),
    .iExIsLoad  (iExIsLoad),
    .iWbEn      (iWbEn),
    .iWbAddr    (iWbAddr),
    .iWbData    (iWbData),
    .iFlush     (iFlush),
    .oValid     (oValid),
    .iReady     (iReady),
    .oOpA       (oOpA),
    .oOpB       (oOpB),
    .oDest      (oDest)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [4:0]  src0, src1;
    logic        use0, use1;
    logic [4:0]  dest;
    logic        ex_en;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  dest;
  } exp_t;

  localparam int NV = 16;
  vec_t vt[NV];
  exp_t sb[$];
  int   out_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rec = 0;

  // Register file contents seen by the bench (read-only).
  function automatic logic [31:0] rf_val(input logic [4:0] r);
    case (r)
      5'd3:    return 32'h11;
      5'd4:    return 32'h22;
      default: return 32'hC000_0000 | 32'(r);
    endcase
  endfunction

  always @(posedge iClk) begin
    cyc <= cyc + 1;
    if (oEnRead0) iDataRead0 <= rf_val(oAddrRead0);
    if (oEnRead1) iDataRead1 <= rf_val(oAddrRead1);
  end

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (iRst_n && oValid && iReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got dest %0d expected none", oDest);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_a_b_dest", {oOpA, oOpB, 27'(oDest)},
            {e.a, e.b, 27'(e.dest)});
        if (rec) out_cyc.push_back(cyc);
      end
    end
  end

  function automatic vec_t mk(
    input logic [4:0] s0, input logic [4:0] s1,
    input logic u0, input logic u1, input logic [4:0] d,
    input logic xe, input logic [4:0] xa, input logic [31:0] xd,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.src0 = s0; v.src1 = s1; v.use0 = u0; v.use1 = u1; v.dest = d;
    v.ex_en = xe; v.ex_addr = xa; v.ex_data = xd;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clr();
    iValid = 0; iSrc0 = 0; iSrc1 = 0; iUse0 = 0; iUse1 = 0; iDest = 0;
    iExEn = 0; iExAddr = 0; iExData = 0; iExIsLoad = 0;
    iWbEn = 0; iWbAddr = 0; iWbData = 0; iFlush = 0;
  endtask

  task automatic acc(input logic [4:0] s0, input logic [4:0] s1,
                     input logic u0, input logic u1, input logic [4:0] d);
    iValid = 1; iSrc0 = s0; iSrc1 = s1; iUse0 = u0; iUse1 = u1; iDest = d;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d);
    exp_t e;
    e.a = a; e.b = b; e.dest = d;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++)
      vt[i] = mk(3, 4, 1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 32'h11, 32'h22);
    vt[8]  = mk(3, 4, 1, 1, 9, 1, 3, 32'hAA, 1, 3, 32'hBB, 32'hAA, 32'h22);
    vt[9]  = mk(6, 7, 1, 1, 10, 0, 0, 0, 1, 7, 32'h77,
                32'hC000_0006, 32'h77);
    vt[10] = mk(0, 4, 1, 1, 11, 1, 0, 32'hFF, 0, 0, 0, 32'h0, 32'h22);
    vt[11] = mk(3, 4, 0, 1, 12, 1, 3, 32'hEE, 0, 0, 0, 32'h0, 32'h22);
    vt[12] = mk(1, 2, 1, 1, 13, 1, 17, 32'hDD, 1, 18, 32'hCC,
                32'hC000_0001, 32'hC000_0002);
    vt[13] = mk(9, 10, 1, 1, 14, 1, 9, 32'h99, 1, 10, 32'h1010,
                32'h99, 32'h1010);
    vt[14] = mk(0, 0, 1, 1, 15, 0, 0, 0, 1, 0, 32'h5A, 32'h0, 32'h0);
    vt[15] = mk(8, 8, 1, 1, 16, 1, 8, 32'h88, 1, 8, 32'h81,
                32'h88, 32'h88);

    clr();
    iReady = 1;
    iDataRead0 = 0;
    iDataRead1 = 0;
    iRst_n = 0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_valid", 96'(oValid), 96'(0));
    chk("rst_ops", {oOpA, oOpB, 27'(oDest)}, 96'(0));
    chk("rst_ready", 96'(oReady), 96'(1));
    chk("rst_rd", {oEnRead0, oEnRead1, oAddrRead0, oAddrRead1}, 96'(0));
    @(negedge iClk);
    iRst_n = 1;
    tick();

    // Table: one vector accepted per cycle, forwards in its resolve cycle.
    rec = 1;
    for (int c = 0; c <= NV; c++) begin
      clr();
      if (c < NV) begin
        acc(vt[c].src0, vt[c].src1, vt[c].use0, vt[c].use1, vt[c].dest);
        push(vt[c].exp_a, vt[c].exp_b, vt[c].dest);
      end
      if (c > 0) begin
        iExEn = vt[c-1].ex_en; iExAddr = vt[c-1].ex_addr;
        iExData = vt[c-1].ex_data;
        iWbEn = vt[c-1].wb_en; iWbAddr = vt[c-1].wb_addr;
        iWbData = vt[c-1].wb_data;
      end
      @(negedge iClk);
      if (c < NV) chk("tbl_ready", 96'(oReady), 96'(1));
      tick();
    end
    clr();
    repeat (4) tick();
    rec = 0;
    chk("tbl_count", 96'(out_cyc.size()), 96'(NV));
    for (int i = 0; i + 1 < out_cyc.size(); i++)
      chk("tbl_no_gap", 96'(out_cyc[i+1] - out_cyc[i]), 96'(1));

    // Load-use on src1=5, then one bubble and WB supplies 0x55.
    acc(2, 5, 1, 1, 20);
    push(32'hC000_0002, 32'h55, 20);
    tick();
    acc(3, 4, 1, 1, 21);
    iExEn = 1; iExIsLoad = 1; iExAddr = 5; iExData = 32'hDEAD;
    @(negedge iClk);
    chk("lu_ready_low", 96'(oReady), 96'(0));
    chk("lu_reread", {oEnRead1, oAddrRead1}, {1'b1, 5'd5});
    tick();
    iExEn = 0; iExIsLoad = 0; iExAddr = 0; iExData = 0;
    iWbEn = 1; iWbAddr = 5; iWbData = 32'h55;
    push(32'h11, 32'h22, 21);
    @(negedge iClk);
    chk("lu_ready_back", 96'(oReady), 96'(1));
    chk("lu_bubble", 96'(oValid), 96'(0));
    tick();
    clr();
    @(negedge iClk);
    chk("lu_out_valid", 96'(oValid), 96'(1));
    tick();
    repeat (3) tick();

    // Backpressure with a WB snoop into the held operand A.
    acc(6, 7, 1, 1, 22);
    push(32'h77, 32'hC000_0007, 22);
    tick();
    acc(3, 4, 1, 1, 23);
    push(32'h11, 32'h22, 23);
    tick();
    clr();
    iReady = 0;
    @(negedge iClk);
    chk("bp_valid", 96'(oValid), 96'(1));
    chk("bp_ready_low", 96'(oReady), 96'(0));
    chk("bp_hold_a", 96'(oOpA), 96'(32'hC000_0006));
    chk("bp_reissue", {oEnRead0, oAddrRead0}, {1'b1, 5'd3});
    tick();
    iWbEn = 1; iWbAddr = 6; iWbData = 32'h77;
    @(negedge iClk);
    chk("bp_stable", {oOpA, oOpB}, {32'hC000_0006, 32'hC000_0007});
    chk("bp_ready_low2", 96'(oReady), 96'(0));
    tick();
    clr();
    @(negedge iClk);
    chk("bp_snoop_a", 96'(oOpA), 96'(32'h77));
    chk("bp_ready_low3", 96'(oReady), 96'(0));
    tick();
    iReady = 1;
    @(negedge iClk);
    chk("bp_release_ready", 96'(oReady), 96'(1));
    tick();
    repeat (3) tick();

    // Flush with both stages full; same-cycle accept is discarded.
    acc(3, 4, 1, 1, 24);
    push(32'h11, 32'h22, 24);
    tick();
    acc(2, 1, 1, 1, 25);
    tick();
    acc(6, 7, 1, 1, 26);
    iFlush = 1;
    @(negedge iClk);
    chk("fl_full", 96'(oValid), 96'(1));
    tick();
    clr();
    @(negedge iClk);
    chk("fl_empty", 96'(oValid), 96'(0));
    tick();
    @(negedge iClk);
    chk("fl_discard", 96'(oValid), 96'(0));
    tick();

    // Asynchronous reset mid-stream.
    acc(3, 4, 1, 1, 27);
    push(32'h11, 32'h22, 27);
    tick();
    acc(6, 7, 1, 1, 28);
    push(32'hC000_0006, 32'hC000_0007, 28);
    tick();
    acc(1, 2, 1, 1, 29);
    tick();
    clr();
    chk("mid_pre_valid", 96'(oValid), 96'(1));
    #1;
    iRst_n = 0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 96'(oValid), 96'(0));
    chk("mid_rst_ops", {oOpA, oOpB, 27'(oDest)}, 96'(0));
    chk("mid_rst_ready", 96'(oReady), 96'(1));
    chk("mid_rst_rd", {oEnRead0, oEnRead1, oAddrRead0, oAddrRead1},
        96'(0));
    @(negedge iClk);
    iRst_n = 1;
    tick();
    acc(4, 3, 1, 1, 30);
    push(32'h22, 32'h11, 30);
    tick();
    clr();
    repeat (4) tick();

    chk("sb_empty", 96'(sb.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
